// File: rtl/alarm_timegen_pkg.sv
// Shared timebase constants for the alarm-clock datapath.
// Counter widths are derived locally by each user from its own parameters.
package alarm_pkg;
  localparam int CLK_PER_SEC_DEF = 256;
  localparam int SEC_PER_MIN_DEF = 60;
endpackage

// File: rtl/alarm_timegen_if.sv
// Timebase bundle between alarm_timegen (slave side) and the control FSM (master side).
interface alarm_timegen_if import alarm_pkg::*; #(
  parameter int SEC_PER_MIN = SEC_PER_MIN_DEF
);
  localparam int SW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;

  logic          reset_count;
  logic          fast_watch;
  logic          one_second;
  logic          one_minute;
  logic [SW-1:0] sec_count;

  modport master (
    output reset_count, fast_watch,
    input  one_second, one_minute, sec_count
  );

  modport slave (
    input  reset_count, fast_watch,
    output one_second, one_minute, sec_count
  );
endinterface

// File: rtl/alarm_timegen_mod_counter.sv
// Modulo-N counter 0..N-1 with synchronous clear (priority over enable) and a
// combinational wrap flag that is high on the enabled cycle where count == N-1.
module mod_counter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  assign wrap = enable && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= wrap ? '0 : count + W'(1);
  end
endmodule

// File: rtl/alarm_timegen.sv
// Divides clock into registered one_second / one_minute pulses and a seconds count;
// reset_count restarts the whole timebase and fast_watch makes minutes tick every second.
module alarm_timegen import alarm_pkg::*; #(
  parameter int CLK_PER_SEC = CLK_PER_SEC_DEF,
  parameter int SEC_PER_MIN = SEC_PER_MIN_DEF
) (
  input  logic            clock,
  input  logic            reset,
  alarm_timegen_if.slave  bus
);
  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int SW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;

  if (CLK_PER_SEC < 2 || SEC_PER_MIN < 2) begin : g_bad_param
    $error("alarm_timegen: CLK_PER_SEC and SEC_PER_MIN must both be >= 2");
  end

  logic [PW-1:0] presc;
  logic [SW-1:0] sec_cnt;
  logic          tick;
  logic          sec_wrap;
  logic          one_second_q;
  logic          one_minute_q;

  mod_counter #(.N(CLK_PER_SEC), .W(PW)) u_presc (
    .clock  (clock),
    .reset  (reset),
    .clear  (bus.reset_count),
    .enable (1'b1),
    .count  (presc),
    .wrap   (tick)
  );

  mod_counter #(.N(SEC_PER_MIN), .W(SW)) u_seconds (
    .clock  (clock),
    .reset  (reset),
    .clear  (bus.reset_count),
    .enable (tick),
    .count  (sec_cnt),
    .wrap   (sec_wrap)
  );

  // fast_watch only matters on tick edges, since both pulse sources are gated by tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      one_second_q <= 1'b0;
      one_minute_q <= 1'b0;
    end else if (bus.reset_count) begin
      one_second_q <= 1'b0;
      one_minute_q <= 1'b0;
    end else begin
      one_second_q <= tick;
      one_minute_q <= bus.fast_watch ? tick : sec_wrap;
    end
  end

  assign bus.one_second = one_second_q;
  assign bus.one_minute = one_minute_q;
  assign bus.sec_count  = sec_cnt;

  // Non-power-of-2 prescalers must never run past their last state.
  a_presc_range: assert property (@(posedge clock) disable iff (reset)
    presc <= PW'(CLK_PER_SEC - 1));
endmodule
